// File: rtl/alu_iterative_if.sv
// alu_iterative_if: request/result bundle between the core control logic and alu_iterative.
// The core drives the master modport; the ALU implements the slave modport.
interface alu_iterative_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start_i;
  logic [3:0]            ALU_OP_i;
  logic [DATA_WIDTH-1:0] ALU_IN_1_i;
  logic [DATA_WIDTH-1:0] ALU_IN_2_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] ALU_RESULT_o;
  logic                  ZERO_o;

  modport master (
    output start_i, ALU_OP_i, ALU_IN_1_i, ALU_IN_2_i,
    input  busy_o, done_o, ALU_RESULT_o, ZERO_o
  );

  modport slave (
    input  start_i, ALU_OP_i, ALU_IN_1_i, ALU_IN_2_i,
    output busy_o, done_o, ALU_RESULT_o, ZERO_o
  );
endinterface

// File: rtl/alu_iterative.sv
// alu_iterative: multi-cycle integer ALU with a start/busy/done handshake.
// Logic, add/sub and compares finish in one cycle. Shifts run one bit per cycle
// unless ALU_FAST_SHIFT_EN is defined, which builds a single-cycle barrel shifter
// and removes the shift FSM (busy_o is then tied low).
module alu_iterative #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input logic            clk,
  input logic            rst,
  alu_iterative_if.slave bus
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpSum  = 4'b0010;
  localparam logic [3:0] OpEq   = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpXor  = 4'b1000;
  localparam logic [3:0] OpNor  = 4'b1001;
  localparam logic [3:0] OpSub  = 4'b1010;
  localparam logic [3:0] OpGe   = 4'b1100;
  localparam logic [3:0] OpGeU  = 4'b1101;
  localparam logic [3:0] OpSlt  = 4'b1110;
  localparam logic [3:0] OpSltU = 4'b1111;

  localparam logic [DATA_WIDTH-2:0] CmpPad = '0;

  logic [DATA_WIDTH-1:0]  a, b;
  logic [3:0]             op;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   lt_s, lt_u;
  logic [DATA_WIDTH-1:0]  op_result;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   done_q, done_d;

  assign a     = bus.ALU_IN_1_i;
  assign b     = bus.ALU_IN_2_i;
  assign op    = bus.ALU_OP_i;
  assign shamt = b[SHAMT_WIDTH-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  // Single-cycle result for the current inputs; compares are zero-extended to bit 0.
  always_comb begin
    op_result = '0;
    case (op)
      OpAnd:  op_result = a & b;
      OpOr:   op_result = a | b;
      OpSum:  op_result = a + b;
      OpEq:   op_result = {CmpPad, a == b};
`ifdef ALU_FAST_SHIFT_EN
      OpSll:  op_result = a << shamt;
      OpSrl:  op_result = a >> shamt;
      OpSra:  op_result = $signed(a) >>> shamt;
`else
      // Only reached with a zero shift amount; non-zero shifts go through the FSM.
      OpSll, OpSrl, OpSra: op_result = a;
`endif
      OpXor:  op_result = a ^ b;
      OpNor:  op_result = ~(a | b);
      OpSub:  op_result = a - b;
      OpGe:   op_result = {CmpPad, ~lt_s};
      OpGeU:  op_result = {CmpPad, ~lt_u};
      OpSlt:  op_result = {CmpPad, lt_s};
      OpSltU: op_result = {CmpPad, lt_u};
      default: op_result = '0;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN

  // Every request completes on the edge that accepts it.
  always_comb begin
    result_d = result_q;
    done_d   = 1'b0;
    if (bus.start_i) begin
      result_d = op_result;
      done_d   = 1'b1;
    end
  end

  // Result and done registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy_o = 1'b0;

`else

  typedef enum logic {StIdle, StShift} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  work_q, work_d;
  logic [SHAMT_WIDTH-1:0] count_q, count_d;
  logic                   shl_q, shl_d;
  logic                   fill_q, fill_d;
  logic                   is_shift;
  logic [DATA_WIDTH-1:0]  work_shifted;

  assign is_shift = (op == OpSll) || (op == OpSrl) || (op == OpSra);

  // fill_q holds the bit entering at the MSB: 0 for logical, original A[MSB] for arithmetic.
  assign work_shifted = shl_q ? {work_q[DATA_WIDTH-2:0], 1'b0}
                              : {fill_q, work_q[DATA_WIDTH-1:1]};

  // Next-state logic: accept in idle, one shift step per cycle in StShift.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    shl_d    = shl_q;
    fill_d   = fill_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          if (is_shift && (shamt != '0)) begin
            work_d  = a;
            count_d = shamt;
            shl_d   = (op == OpSll);
            fill_d  = (op == OpSra) && a[DATA_WIDTH-1];
            state_d = StShift;
          end else begin
            result_d = op_result;
            done_d   = 1'b1;
          end
        end
      end
      StShift: begin
        work_d  = work_shifted;
        count_d = count_q - SHAMT_WIDTH'(1);
        if (count_q == SHAMT_WIDTH'(1)) begin
          result_d = work_shifted;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, working register and result registers; reset discards any in-flight shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      work_q   <= '0;
      count_q  <= '0;
      shl_q    <= 1'b0;
      fill_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      shl_q    <= shl_d;
      fill_q   <= fill_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy_o = (state_q == StShift);

`endif

  assign bus.done_o       = done_q;
  assign bus.ALU_RESULT_o = result_q;
  assign bus.ZERO_o       = (result_q == '0);

endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: directed self-checking bench for alu_iterative.
// Expected latencies follow the build (ALU_FAST_SHIFT_EN gives latency 1 everywhere).
module tb_alu_iterative;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpSum  = 4'b0010;
  localparam logic [3:0] OpEq   = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpXor  = 4'b1000;
  localparam logic [3:0] OpNor  = 4'b1001;
  localparam logic [3:0] OpSub  = 4'b1010;
  localparam logic [3:0] OpGe   = 4'b1100;
  localparam logic [3:0] OpGeU  = 4'b1101;
  localparam logic [3:0] OpSlt  = 4'b1110;
  localparam logic [3:0] OpSltU = 4'b1111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_iterative_if #(.DATA_WIDTH(32)) bus ();

  alu_iterative #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  int          lat;
  int          bsy;
  int          dones;
  logic [31:0] res;
  logic        got_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int n);
    return (FAST || n == 0) ? 1 : n + 1;
  endfunction

  // Issue one request (caller is just after a rising edge) and wait for done_o.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start_i    = 1'b1;
    bus.ALU_OP_i   = op;
    bus.ALU_IN_1_i = a;
    bus.ALU_IN_2_i = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    lat = 1;
    bsy = 0;
    while (!bus.done_o && lat < 64) begin
      if (bus.busy_o) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    got_done = bus.done_o;
    res      = bus.ALU_RESULT_o;
  endtask

  logic [3:0]  s_op [10];
  logic [31:0] s_exp[10];

  initial begin
    bus.start_i    = 1'b0;
    bus.ALU_OP_i   = 4'b0000;
    bus.ALU_IN_1_i = '0;
    bus.ALU_IN_2_i = '0;

    // Reset state
    #2;
    check("rst_result", bus.ALU_RESULT_o, 32'h0);
    check("rst_zero", 32'(bus.ZERO_o), 32'd1);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset mid-shift
    bus.start_i = 1'b1; bus.ALU_OP_i = OpSll;
    bus.ALU_IN_1_i = 32'h1; bus.ALU_IN_2_i = 32'd31;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    check("midrst_result", bus.ALU_RESULT_o, 32'h0);
    check("midrst_zero", 32'(bus.ZERO_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done_o) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);

    run(OpSum, 32'd3, 32'd4);
    check("sum_done", 32'(got_done), 32'd1);
    check("sum_res", res, 32'd7);
    check("sum_lat", 32'(lat), 32'd1);
    check("sum_zero", 32'(bus.ZERO_o), 32'd0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done_o), 32'd0);

    // SUB wrap and compares
    run(OpSub, 32'h0, 32'h1);
    check("sub_wrap", res, 32'hFFFF_FFFF);
    check("sub_zero", 32'(bus.ZERO_o), 32'd0);
    run(OpSlt, 32'hFFFF_FFFF, 32'h0);
    check("slt", res, 32'd1);
    run(OpSltU, 32'hFFFF_FFFF, 32'h0);
    check("sltu", res, 32'd0);
    run(OpGeU, 32'd5, 32'd5);
    check("geu_eq", res, 32'd1);
    run(OpGe, 32'hFFFF_FFFE, 32'h1);
    check("ge_neg", res, 32'd0);
    check("ge_zero_flag", 32'(bus.ZERO_o), 32'd1);

    // Arithmetic / logical right shift
    run(OpSra, 32'h8000_0000, 32'd4);
    check("sra_res", res, 32'hF800_0000);
    check("sra_lat", 32'(lat), 32'(exp_lat(4)));
    check("sra_busy", 32'(bsy), FAST ? 32'd0 : 32'd4);
    check("sra_busy_drop", 32'(bus.busy_o), 32'd0);
    run(OpSrl, 32'h8000_0000, 32'd4);
    check("srl_res", res, 32'h0800_0000);

    // Shift edge cases
    run(OpSll, 32'hA5, 32'h20);
    check("sll_n0_res", res, 32'hA5);
    check("sll_n0_lat", 32'(lat), 32'd1);
    run(OpSll, 32'hA5, 32'h1F);
    check("sll_31_res", res, 32'h8000_0000);
    check("sll_31_lat", 32'(lat), 32'(exp_lat(31)));

    // Ignored request during an 8-bit shift
    dones = 0;
    bus.start_i = 1'b1; bus.ALU_OP_i = OpSll;
    bus.ALU_IN_1_i = 32'h1; bus.ALU_IN_2_i = 32'd8;
    @(posedge clk); #1;
    if (bus.done_o) begin dones++; res = bus.ALU_RESULT_o; end
    bus.ALU_OP_i = OpSum; bus.ALU_IN_1_i = 32'd3; bus.ALU_IN_2_i = 32'd4;
    @(posedge clk); #1;
    if (bus.done_o) begin dones++; res = bus.ALU_RESULT_o; end
    bus.start_i = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done_o) begin dones++; res = bus.ALU_RESULT_o; end
    end
    check("ignore_dones", 32'(dones), FAST ? 32'd2 : 32'd1);
    check("ignore_res", res, FAST ? 32'd7 : 32'h100);

    // Unassigned opcodes give zero in one cycle
    run(4'b0110, 32'hFFFF_FFFF, 32'h1);
    check("op0110", res, 32'h0);
    check("op0110_lat", 32'(lat), 32'd1);
    run(4'b1011, 32'h1234, 32'h1);
    check("op1011", res, 32'h0);

    // Streaming: A=F0F01234, B=0FF000FF, start held high for 10 cycles
    s_op[0] = OpAnd;  s_exp[0] = 32'h00F0_0034;
    s_op[1] = OpOr;   s_exp[1] = 32'hFFF0_12FF;
    s_op[2] = OpXor;  s_exp[2] = 32'hFF00_12CB;
    s_op[3] = OpNor;  s_exp[3] = 32'h000F_ED00;
    s_op[4] = OpEq;   s_exp[4] = 32'h0;
    s_op[5] = OpSum;  s_exp[5] = 32'h00E0_1333;
    s_op[6] = OpSub;  s_exp[6] = 32'hE100_1135;
    s_op[7] = OpGe;   s_exp[7] = 32'h0;
    s_op[8] = OpGeU;  s_exp[8] = 32'h1;
    s_op[9] = OpSlt;  s_exp[9] = 32'h1;
    bus.ALU_IN_1_i = 32'hF0F0_1234;
    bus.ALU_IN_2_i = 32'h0FF0_00FF;
    bus.start_i    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.ALU_OP_i = s_op[i];
      @(posedge clk); #1;
      check($sformatf("stream_done%0d", i), 32'(bus.done_o), 32'd1);
      check($sformatf("stream_res%0d", i), bus.ALU_RESULT_o, s_exp[i]);
      check($sformatf("stream_busy%0d", i), 32'(bus.busy_o), 32'd0);
    end
    bus.start_i = 1'b0;
    @(posedge clk); #1;

    // Branch flag
    run(OpEq, 32'd3, 32'd4);
    check("eq_ne_res", res, 32'd0);
    check("eq_ne_zero", 32'(bus.ZERO_o), 32'd1);
    run(OpEq, 32'd7, 32'd7);
    check("eq_eq_zero", 32'(bus.ZERO_o), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Multi-cycle integer ALU that sits directly downstream of the ALU control decoder and consumes its 4-bit operation code. Logic, add/sub and compare operations complete in one cycle. Shifts run iteratively, one bit per cycle, to save area, unless the barrel-shifter option is compiled in. A start/busy/done handshake lets the core's control FSM stall while a shift is in progress.

## Interface
- DATA_WIDTH, 32, operand and result width; must be a power of two, ≥ 8
- SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount width taken from ALU_IN_2_i LSBs
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- start_i  input  1  request; sampled only when busy_o=0
- ALU_OP_i  input  4  operation code from ALU control
- ALU_IN_1_i  input  DATA_WIDTH  operand A
- ALU_IN_2_i  input  DATA_WIDTH  operand B; for shifts, only bits [SHAMT_WIDTH-1:0] are used
- busy_o  input-blocking flag, output  1  high while an iterative shift is in progress
- done_o  output  1  one-cycle pulse when ALU_RESULT_o is updated
- ALU_RESULT_o  output  DATA_WIDTH  registered result, held until the next completion
- ZERO_o  output  1  combinational (ALU_RESULT_o == 0)

## Operation
- Opcodes and results:
  - 0000 AND: A&B
  - 0001 OR: A|B
  - 0010 SUM: A+B, modulo 2^DATA_WIDTH
  - 0011 EQUAL: 1 if A==B, else 0
  - 0100 SHIFT_LEFT: A<<n
  - 0101 SHIFT_RIGHT: logical A>>n
  - 0111 SHIFT_RIGHT_A: arithmetic A>>>n
  - 1000 XOR: A^B
  - 1001 NOR: ~(A|B)
  - 1010 SUB: A-B
  - 1100 GREATER_EQUAL: signed A≥B
  - 1101 GREATER_EQUAL_U: unsigned A≥B
  - 1110 SLT: signed A<B
  - 1111 SLT_U: unsigned A<B
- Compare results are zero-extended to a 1 or 0 in bit 0.
- Opcodes 0110 and 1011: result is 0, latency 1.
- Branch use: the taken condition is ZERO_o. EQUAL zero means not-equal; GREATER_EQUAL zero means less-than.
- State machine:
  - IDLE:
    - start_i with a non-shift opcode, or a shift with n=0: compute the result, register it, pulse done_o, stay in IDLE.
    - start_i with a shift and n>0: load the working register with A, load count with n, go to SHIFT.
  - SHIFT: each cycle, shift the working register by 1 in the selected direction and decrement count.
    - Arithmetic right shift refills with the original A[MSB].
    - The cycle in which count==1 shifts: write the result, pulse done_o, return to IDLE.
- Operands and opcode are captured at acceptance. Input changes while busy_o=1 have no effect.
- start_i while busy_o=1 is ignored. It is not queued.
- Reset (asynchronous, any state, including mid-shift):
  - state goes to IDLE
  - ALU_RESULT_o=0, so ZERO_o=1
  - done_o=0, busy_o=0
  - count=0
  - the in-flight operation is discarded.

## Timing
- Call the edge that samples start_i edge 0.
- Non-shift ops and shifts with n=0: done_o and the new ALU_RESULT_o are visible after edge 0. Latency is 1 cycle.
- Shifts with n≥1:
  - busy_o is high after edges 0 through n-1.
  - done_o and the result are visible after edge n.
  - Latency is n+1 cycles. Maximum is DATA_WIDTH cycles (n = DATA_WIDTH-1).
- done_o is high for exactly one cycle per accepted request.
- Back-to-back: start_i may be high in the cycle where done_o=1. That request is accepted because busy_o=0 there, giving one result per cycle for non-shift ops.
- busy_o is a registered output and drops in the same cycle that done_o rises.

## Configuration
- ALU_FAST_SHIFT_EN defined:
  - shifts use a single-cycle barrel shifter
  - the SHIFT state and counter are not built
  - busy_o is tied to 0
  - all opcodes have latency 1.
- ALU_FAST_SHIFT_EN undefined (default): iterative shifter as described above.
- Results are bit-identical in both builds; only the latency differs.

## Test plan
- Reset mid-shift:
  - Stimulus: SHIFT_LEFT, A=1, B=31; assert rst after 5 cycles, then release.
  - Required: busy_o=0, ALU_RESULT_o=0, ZERO_o=1; no done_o pulse follows.
  - Then start SUM, 3+4: result 7 after 1 cycle.
- SUB with wrap and compares:
  - SUB, A=0, B=1: result 0xFFFFFFFF, ZERO_o=0.
  - SLT, A=0xFFFFFFFF, B=0: result 1.
  - SLT_U, same operands: result 0.
  - GREATER_EQUAL_U, A=5, B=5: result 1.
- Arithmetic right shift:
  - SHIFT_RIGHT_A, A=0x80000000, B=4: result 0xF8000000.
  - done_o is seen exactly 5 cycles after acceptance; busy_o is high for 4 cycles.
  - SHIFT_RIGHT with the same operands: 0x08000000.
- Shift edge cases:
  - SHIFT_LEFT, A=0xA5, B=0x20 (n=0): result 0xA5, latency 1.
  - B=0x1F: result 0x80000000, latency 32.
- Ignored request during a shift:
  - Issue start_i with SUM during an 8-bit shift.
  - Required: only the shift result appears, with a single done_o pulse.
- Streaming and branch flags:
  - 10 back-to-back requests (AND, OR, XOR, NOR, EQUAL, ...): one done_o per cycle with correct results.
  - EQUAL, A=3, B=4: ZERO_o=1.
  - Repeat the whole plan with ALU_FAST_SHIFT_EN defined: latency is 1 and busy_o stays 0 throughout.
